dcache_direct_mapped: RTL and testbench
=======================================

// Module: dcache_direct_mapped
// PURPOSE
// Write-back, write-allocate, direct-mapped data cache between the CPU MEM stage and data_memory.
// Serves 32-bit word and byte-masked accesses in the same cycle on a hit.
// On a miss it stalls the CPU, writes back a dirty victim, then fetches the 128-bit block
// over data_memory's block interface (28-bit block address, BUSYWAIT handshake).
// PARAMETERS
// INDEX_W    3   log2 of line count; NUM_LINES = 2**INDEX_W, tag width TAG_W = 28-INDEX_W
// PORTS
// CLOCK            in   1    system clock, all state updates on posedge
// RESET_N          in   1    asynchronous, active-low reset
// CPU_READ         in   1    load request
// CPU_WRITE        in   1    store request; wins if both CPU_READ and CPU_WRITE are high
// CPU_ADDRESS      in   32   byte address: [3:2] word, [3+INDEX_W:4] index, [31:4+INDEX_W] tag
// CPU_BYTE_EN      in   4    store byte mask, bit i -> CPU_WRITE_DATA[8i+7:8i]
// CPU_WRITE_DATA   in   32   store data
// CPU_READ_DATA    out  32   load data, valid when CPU_READ=1 and CPU_BUSYWAIT=0
// CPU_BUSYWAIT     out  1    stall CPU; high while request is not a hit
// MEM_READ_EN      out  1    to data_memory READ_EN
// MEM_WRITE_EN     out  1    to data_memory WRITE_EN
// MEM_ADDRESS      out  28   block address to data_memory
// MEM_WRITE_DATA   out  128  victim block, word0 in [31:0]
// MEM_READ_DATA    in   128  fetched block from data_memory
// MEM_BUSYWAIT     in   1    data_memory busy; access completes at posedge where it is low
// BEHAVIOUR
// - Storage per line: valid, dirty, TAG_W-bit tag, 128-bit data. Regs, no SRAM macro.
// - Reset (RESET_N=0, async): all valid/dirty=0, FSM=IDLE, MEM_READ_EN=MEM_WRITE_EN=0,
//   MEM_ADDRESS=0, MEM_WRITE_DATA=0. CPU_BUSYWAIT=0 with no request. Data/tag arrays not cleared.
// - Mid-operation reset aborts any memory transfer. The line being filled stays invalid.
// - hit = valid[idx] && tag[idx]==CPU_ADDRESS[31:4+INDEX_W]; evaluated combinationally.
// - CPU_BUSYWAIT = (CPU_READ|CPU_WRITE) && !(state==IDLE && hit).
// - Read hit: CPU_READ_DATA = selected word, same cycle, zero stall. Otherwise CPU_READ_DATA=0.
// - Write hit: at posedge, bytes selected by CPU_BYTE_EN are written and dirty[idx] is set.
//   CPU_BYTE_EN=0 leaves the data unchanged but still sets dirty.
// - FSM states: IDLE, WRITE_BACK, FETCH, UPDATE.
//   IDLE: on miss with valid&dirty -> WRITE_BACK. On miss otherwise -> FETCH. Else stay.
//   WRITE_BACK: MEM_WRITE_EN=1, MEM_ADDRESS={old tag,idx}, MEM_WRITE_DATA=line data.
//     On posedge with MEM_BUSYWAIT=0 -> FETCH.
//   FETCH: MEM_READ_EN=1, MEM_ADDRESS=CPU_ADDRESS[31:4]. On posedge with MEM_BUSYWAIT=0,
//     latch MEM_READ_DATA -> UPDATE.
//   UPDATE: enables low. Write block and tag; valid=1, dirty=0. -> IDLE.
//     The next cycle hits and releases the CPU; a store then merges as a write hit.
// - Enables are registered outputs of the state and drop the cycle after completion.
//   MEM_READ_EN and MEM_WRITE_EN are never high together, so data_memory sees a clean
//   per-access 16-beat count.
// - Miss penalty, clean line: 1 (IDLE) + FETCH length + 1 (UPDATE) + 1 hit cycle.
//   Dirty line: add the WRITE_BACK length.
// - Request dropped during a miss: the transfer completes and the line fills. No CPU side effect.
// - CPU_ADDRESS/data must be held stable while CPU_BUSYWAIT=1. Bits [1:0] are ignored.
// TESTING
// - Reset then read 0x0000_0040 with memory block 0x4 = 0x..._DDDD_CCCC_BBBB_AAAA ->
//   busywait ~18 cycles, then 0xAAAA_AAAA returned; immediate re-read hits with 0 stall.
// - Write 0x1234_5678 to 0x44 (hit, BYTE_EN=4'hF) -> no stall. Read 0x44 -> 0x1234_5678.
//   Line dirty, no MEM access.
// - Read 0x1044 (same index 4, new tag) -> WRITE_BACK to block 0x4 with word1=0x1234_5678,
//   then FETCH block 0x104. Later read 0x44 -> 0x1234_5678 refetched from memory.
// - Byte write BYTE_EN=4'b0010, data 0x0000_AB00 to a hit word 0x1111_1111 -> reads 0x1111_AB11.
// - Assert RESET_N=0 mid-FETCH -> enables drop immediately. After release, the same read
//   misses again and completes correctly.
// - CPU_READ and CPU_WRITE high together on a hit -> treated as write. Memory enables stay 0.

Source files
------------

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - write-back, write-allocate direct-mapped data cache
//
// Purpose: sits between the CPU MEM stage and data_memory. Hits are served in the
// same cycle. A miss stalls the CPU, writes back a dirty victim block, and then
// fetches the 128-bit block over the data_memory block interface.
//
// Ports:
//   CLOCK, RESET_N        clock, asynchronous active-low reset
//   CPU_READ/CPU_WRITE    load/store request (a store wins if both are high)
//   CPU_ADDRESS           byte address: [3:2] word, [3+INDEX_W:4] index, [31:4+INDEX_W] tag
//   CPU_BYTE_EN           store byte mask
//   CPU_WRITE_DATA        store data
//   CPU_READ_DATA         load data (valid on a read hit, otherwise 0)
//   CPU_BUSYWAIT          CPU stall
//   MEM_READ_EN/WRITE_EN  registered block-transfer enables to data_memory
//   MEM_ADDRESS           28-bit block address
//   MEM_WRITE_DATA        victim block, word0 in [31:0]
//   MEM_READ_DATA         fetched block
//   MEM_BUSYWAIT          data_memory busy; an access completes on a posedge where it is low
module dcache_direct_mapped #(
  parameter int INDEX_W = 3
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          CPU_READ,
  input  logic          CPU_WRITE,
  input  logic [31:0]   CPU_ADDRESS,
  input  logic [3:0]    CPU_BYTE_EN,
  input  logic [31:0]   CPU_WRITE_DATA,
  output logic [31:0]   CPU_READ_DATA,
  output logic          CPU_BUSYWAIT,
  output logic          MEM_READ_EN,
  output logic          MEM_WRITE_EN,
  output logic [27:0]   MEM_ADDRESS,
  output logic [127:0]  MEM_WRITE_DATA,
  input  logic [127:0]  MEM_READ_DATA,
  input  logic          MEM_BUSYWAIT
);

  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam int TAG_W     = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_e;

  state_e               state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  logic                 mem_read_en_q;
  logic                 mem_write_en_q;
  logic [27:0]          mem_address_q;
  logic [127:0]         mem_write_data_q;
  logic [127:0]         fill_q;
  // The missing line is captured so a dropped request still fills the right line.
  logic [INDEX_W-1:0]   miss_idx_q;
  logic [TAG_W-1:0]     miss_tag_q;

  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic [1:0]           word;
  logic                 hit;
  logic                 idle_hit;
  logic                 req;
  logic [127:0]         line;
  logic [31:0]          word_d;
  logic [127:0]         line_d;

  assign idx      = CPU_ADDRESS[3+INDEX_W:4];
  assign tag      = CPU_ADDRESS[31:4+INDEX_W];
  assign word     = CPU_ADDRESS[3:2];
  assign line     = data_q[idx];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign req      = CPU_READ | CPU_WRITE;
  assign idle_hit = (state_q == IDLE) && hit;

  assign CPU_BUSYWAIT  = req && !idle_hit;
  assign CPU_READ_DATA = (CPU_READ && idle_hit) ? line[{word, 5'b0} +: 32] : 32'h0;

  assign MEM_READ_EN    = mem_read_en_q;
  assign MEM_WRITE_EN   = mem_write_en_q;
  assign MEM_ADDRESS    = mem_address_q;
  assign MEM_WRITE_DATA = mem_write_data_q;

  // Byte-merge the store into the addressed word of the current line.
  always_comb begin
    word_d = line[{word, 5'b0} +: 32];
    for (int b = 0; b < 4; b++) begin
      if (CPU_BYTE_EN[b]) word_d[8*b +: 8] = CPU_WRITE_DATA[8*b +: 8];
    end
    line_d = line;
    line_d[{word, 5'b0} +: 32] = word_d;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q          <= IDLE;
      valid_q          <= '0;
      dirty_q          <= '0;
      mem_read_en_q    <= 1'b0;
      mem_write_en_q   <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      fill_q           <= '0;
      miss_idx_q       <= '0;
      miss_tag_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CPU_WRITE && hit) begin
            dirty_q[idx] <= 1'b1;
          end else if (req && !hit) begin
            miss_idx_q <= idx;
            miss_tag_q <= tag;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q          <= WRITE_BACK;
              mem_write_en_q   <= 1'b1;
              mem_address_q    <= {tag_q[idx], idx};
              mem_write_data_q <= line;
            end else begin
              state_q       <= FETCH;
              mem_read_en_q <= 1'b1;
              mem_address_q <= CPU_ADDRESS[31:4];
            end
          end
        end
        WRITE_BACK: begin
          if (!MEM_BUSYWAIT) begin
            state_q        <= FETCH;
            mem_write_en_q <= 1'b0;
            mem_read_en_q  <= 1'b1;
            mem_address_q  <= {miss_tag_q, miss_idx_q};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state_q       <= UPDATE;
            mem_read_en_q <= 1'b0;
            fill_q        <= MEM_READ_DATA;
          end
        end
        UPDATE: begin
          state_q             <= IDLE;
          valid_q[miss_idx_q] <= 1'b1;
          dirty_q[miss_idx_q] <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays are plain storage and are not cleared by reset.
  always_ff @(posedge CLOCK) begin
    if (state_q == IDLE && CPU_WRITE && hit) begin
      data_q[idx] <= line_d;
    end else if (state_q == UPDATE) begin
      data_q[miss_idx_q] <= fill_q;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb/tb_dcache_direct_mapped.sv - directed self-checking bench for dcache_direct_mapped
module tb_dcache_direct_mapped;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          CPU_READ = 1'b0;
  logic          CPU_WRITE = 1'b0;
  logic [31:0]   CPU_ADDRESS = '0;
  logic [3:0]    CPU_BYTE_EN = '0;
  logic [31:0]   CPU_WRITE_DATA = '0;
  logic [31:0]   CPU_READ_DATA;
  logic          CPU_BUSYWAIT;
  logic          MEM_READ_EN;
  logic          MEM_WRITE_EN;
  logic [27:0]   MEM_ADDRESS;
  logic [127:0]  MEM_WRITE_DATA;
  logic [127:0]  MEM_READ_DATA;
  logic          MEM_BUSYWAIT;

  dcache_direct_mapped #(.INDEX_W(3)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE), .CPU_ADDRESS(CPU_ADDRESS),
    .CPU_BYTE_EN(CPU_BYTE_EN), .CPU_WRITE_DATA(CPU_WRITE_DATA),
    .CPU_READ_DATA(CPU_READ_DATA), .CPU_BUSYWAIT(CPU_BUSYWAIT),
    .MEM_READ_EN(MEM_READ_EN), .MEM_WRITE_EN(MEM_WRITE_EN),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_READ_DATA(MEM_READ_DATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLOCK = ~CLOCK;

  // data_memory model: each access is busy for 16 cycles, completes on the 17th.
  localparam int LAT = 16;
  logic [127:0] mem     [1024];
  logic         written [1024];
  int           cnt = 0;
  int           n_rd = 0;
  int           n_wr = 0;
  logic         overlap = 1'b0;
  logic [27:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;

  function automatic logic [127:0] init_block(input logic [27:0] a);
    case (a)
      28'h4:   return {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      28'h104: return {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      28'h8:   return {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555};
      default: return 128'h0;
    endcase
  endfunction

  assign MEM_READ_DATA = written[MEM_ADDRESS[9:0]] === 1'b1 ? mem[MEM_ADDRESS[9:0]]
                                                           : init_block(MEM_ADDRESS);
  assign MEM_BUSYWAIT  = (MEM_READ_EN | MEM_WRITE_EN) && (cnt != LAT);

  always @(posedge CLOCK) begin
    if (MEM_READ_EN && MEM_WRITE_EN) overlap <= 1'b1;
    if (MEM_READ_EN || MEM_WRITE_EN) begin
      if (cnt == LAT) begin
        cnt <= 0;
        if (MEM_WRITE_EN) begin
          mem[MEM_ADDRESS[9:0]]     <= MEM_WRITE_DATA;
          written[MEM_ADDRESS[9:0]] <= 1'b1;
          wb_addr <= MEM_ADDRESS;
          wb_data <= MEM_WRITE_DATA;
          n_wr    <= n_wr + 1;
        end else begin
          n_rd <= n_rd + 1;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One CPU access; n = stall cycles, rdat = load data when released.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int n, output logic [31:0] rdat);
    @(negedge CLOCK);
    CPU_READ = rd; CPU_WRITE = wr; CPU_ADDRESS = a; CPU_BYTE_EN = be; CPU_WRITE_DATA = wd;
    #1;
    n = 0;
    while (CPU_BUSYWAIT && n < 200) begin
      @(posedge CLOCK); #1;
      n++;
    end
    rdat = CPU_READ_DATA;
    @(posedge CLOCK); #1;
    CPU_READ = 1'b0; CPU_WRITE = 1'b0;
  endtask

  int          n;
  logic [31:0] rd;
  int          rd0, wr0;

  initial begin
    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_busywait", CPU_BUSYWAIT, 0);
    check("rst_read_en", MEM_READ_EN, 0);
    check("rst_write_en", MEM_WRITE_EN, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_mem_wdata", MEM_WRITE_DATA, 0);
    check("rst_rdata", CPU_READ_DATA, 0);
    @(negedge CLOCK); RESET_N = 1'b1;

    // Clean miss: 1 IDLE + 17 FETCH + 1 UPDATE stall cycles.
    access(1, 0, 32'h40, 4'h0, 32'h0, n, rd);
    check("miss_stall", n, 19);
    check("miss_data", rd, 32'hAAAA_AAAA);
    access(1, 0, 32'h40, 4'h0, 32'h0, n, rd);
    check("rehit_stall", n, 0);
    check("rehit_data", rd, 32'hAAAA_AAAA);

    // Write hit makes the line dirty without touching memory.
    rd0 = n_rd; wr0 = n_wr;
    access(0, 1, 32'h44, 4'hF, 32'h1234_5678, n, rd);
    check("wrhit_stall", n, 0);
    access(1, 0, 32'h44, 4'h0, 32'h0, n, rd);
    check("wrhit_read_stall", n, 0);
    check("wrhit_read_data", rd, 32'h1234_5678);
    check("wrhit_no_mem", (n_rd - rd0) + (n_wr - wr0), 0);

    // Conflict miss on a dirty line: write-back adds another 17 cycles.
    access(1, 0, 32'h1044, 4'h0, 32'h0, n, rd);
    check("dirty_stall", n, 36);
    check("dirty_data", rd, 32'h2222_2222);
    check("wb_addr", wb_addr, 28'h4);
    check("wb_data", wb_data, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'h1234_5678, 32'hAAAA_AAAA});
    check("wb_count", n_wr - wr0, 1);
    access(1, 0, 32'h44, 4'h0, 32'h0, n, rd);
    check("refetch_stall", n, 19);
    check("refetch_data", rd, 32'h1234_5678);

    // Byte-masked store into a hit word.
    access(1, 0, 32'h1040, 4'h0, 32'h0, n, rd);
    check("bw_fill_stall", n, 19);
    check("bw_fill_data", rd, 32'h1111_1111);
    access(0, 1, 32'h1040, 4'b0010, 32'h0000_AB00, n, rd);
    check("bw_stall", n, 0);
    access(1, 0, 32'h1040, 4'h0, 32'h0, n, rd);
    check("bw_data", rd, 32'h1111_AB11);

    // Reset in the middle of a fetch.
    @(negedge CLOCK);
    CPU_READ = 1'b1; CPU_ADDRESS = 32'h80;
    repeat (5) @(posedge CLOCK);
    #1;
    check("midfetch_read_en", MEM_READ_EN, 1);
    RESET_N = 1'b0;
    #1;
    check("midrst_read_en", MEM_READ_EN, 0);
    check("midrst_write_en", MEM_WRITE_EN, 0);
    check("midrst_busywait", CPU_BUSYWAIT, 1);
    @(negedge CLOCK);
    RESET_N = 1'b1; CPU_READ = 1'b0;
    access(1, 0, 32'h80, 4'h0, 32'h0, n, rd);
    check("postrst_stall", n, 19);
    check("postrst_data", rd, 32'h5555_5555);

    // Read and write together on a hit behave as a store.
    rd0 = n_rd; wr0 = n_wr;
    access(1, 1, 32'h84, 4'hF, 32'hCAFE_BABE, n, rd);
    check("rw_stall", n, 0);
    check("rw_enables", {MEM_READ_EN, MEM_WRITE_EN}, 0);
    access(1, 0, 32'h84, 4'h0, 32'h0, n, rd);
    check("rw_data", rd, 32'hCAFE_BABE);
    check("rw_no_mem", (n_rd - rd0) + (n_wr - wr0), 0);

    check("enables_exclusive", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
